csa_stream_accumulator: RTL and testbench

Parametrised multi-operand accumulator built on carry-save (3:2) compression. Accepts a stream of WIDTH-bit operands over a valid/ready handshake. Each operand is folded into redundant sum/carry registers in one cycle, with no carry propagation. On the last operand, a multi-cycle chunked carry-propagate stage resolves the result and presents it on an output handshake. Used wherever many terms are summed, e.g. dot-product and checksum datapaths.

---
 rtl/csa_pkg.sv | 10 +
 rtl/csa_row.sv | 13 +
 rtl/csa_stream_accumulator.sv | 99 +++++++++
 tb/tb_csa_stream_accumulator.sv | 130 +++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// csa_pkg: shared state encoding and sizing helpers for the carry-save stream accumulator
package csa_pkg;
  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;
  function automatic int num_chunks(input int acc_width, input int chunk);
    return acc_width / chunk;
  endfunction
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/csa_row.sv
// csa_row: N-bit 3:2 compressor array producing per-bit sum and majority vectors
module csa_row #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] s,
  output logic [N-1:0] m
);
  assign s = a ^ b ^ c;
  assign m = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: carry-save operand accumulator with chunked resolve; CSA_SIGNED_EN selects signed operands
module csa_stream_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int CPA_CHUNK = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic [CNT_WIDTH-1:0] out_count
);
  localparam int NUM_CHUNKS = num_chunks(ACC_WIDTH, CPA_CHUNK);
  localparam int IW = idx_width(NUM_CHUNKS);
`ifdef CSA_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  state_t state, next_state;
  logic [ACC_WIDTH-1:0] sum_r, carry_r, x, row_s, row_m;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [IW-1:0] idx;
  logic [CPA_CHUNK:0] chunk_sum;
  logic ovf_r, cin_r, accept, done, last_chunk;
  assign x = SIGNED_EN ? ACC_WIDTH'($signed(in_data)) : ACC_WIDTH'(in_data);
  assign accept = in_valid & in_ready;
  assign done = out_valid & out_ready;
  assign last_chunk = idx == IW'(NUM_CHUNKS - 1);
  assign out_ovf = ovf_r & ~SIGNED_EN;
  assign out_count = cnt_r;
  csa_row #(.N(ACC_WIDTH)) u_row (
    .a(sum_r),
    .b(carry_r),
    .c(x),
    .s(row_s),
    .m(row_m)
  );
  // one resolve chunk: slice of sum plus slice of carry plus the carry-in from the previous chunk
  always_comb begin
    chunk_sum = {1'b0, sum_r[int'(idx)*CPA_CHUNK +: CPA_CHUNK]} + {1'b0, carry_r[int'(idx)*CPA_CHUNK +: CPA_CHUNK]} + {{CPA_CHUNK{1'b0}}, cin_r};
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else state <= next_state;
  end
  // next-state and handshake outputs
  always_comb begin
    next_state = state;
    in_ready = state == ACCUM;
    out_valid = state == OUTPUT;
    if (state == ACCUM && in_valid && in_last) next_state = RESOLVE;
    if (state == RESOLVE && last_chunk) next_state = OUTPUT;
    if (out_valid && out_ready) next_state = ACCUM;
  end
  // redundant accumulation, chunked carry-propagate, and clear on result handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= '0;
      carry_r <= '0;
      ovf_r <= 1'b0;
      cnt_r <= '0;
      out_data <= '0;
      idx <= '0;
      cin_r <= 1'b0;
    end else begin
      if (accept) begin
        sum_r <= row_s;
        carry_r <= {row_m[ACC_WIDTH-2:0], 1'b0};
        ovf_r <= ovf_r | row_m[ACC_WIDTH-1];
        cnt_r <= &cnt_r ? cnt_r : cnt_r + 1'b1;
        idx <= '0;
        cin_r <= 1'b0;
      end
      if (state == RESOLVE) begin
        out_data[int'(idx)*CPA_CHUNK +: CPA_CHUNK] <= chunk_sum[CPA_CHUNK-1:0];
        cin_r <= chunk_sum[CPA_CHUNK];
        idx <= idx + 1'b1;
        if (last_chunk) ovf_r <= ovf_r | chunk_sum[CPA_CHUNK];
      end
      if (done) begin
        sum_r <= '0;
        carry_r <= '0;
        ovf_r <= 1'b0;
        cnt_r <= '0;
      end
    end
  end
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb_csa_stream_accumulator: directed vectors with hand-computed sums for the carry-save accumulator
module tb_csa_stream_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] in_data = '0;
  logic in_ready, out_valid, out_ovf;
  logic [7:0] out_data, out_count;
  int vectors = 0;
  int errors = 0;
  csa_stream_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .CPA_CHUNK(4), .CNT_WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ovf(out_ovf),
    .out_count(out_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [3:0] d, input logic last);
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic idle_junk();
    in_valid = 1'b0;
    in_data = 4'hA;
    in_last = 1'b1;
    @(negedge clk);
    in_last = 1'b0;
  endtask
  task automatic collect(input string tag, input logic [7:0] d, input logic o, input logic [7:0] n);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_ovf"}, out_ovf, o);
    check({tag, "_count"}, out_count, n);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_count", out_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    send(4'd9, 1'b0);
    send(4'd7, 1'b0);
    send(4'd15, 1'b1);
    check("t1_lat0", out_valid, 0);
    @(negedge clk);
    check("t1_lat1", out_valid, 0);
    @(negedge clk);
    check("t1_lat2", out_valid, 1);
    check("t1_data", out_data, 8'h1F);
    check("t1_ovf", out_ovf, 0);
    check("t1_count", out_count, 3);
    @(negedge clk);
    out_ready = 1'b0;
    check("t1_valid_drop", out_valid, 0);
    check("t1_ready_back", in_ready, 1);
    for (int i = 0; i < 18; i++) send(4'd15, i == 17);
    collect("t2", 8'h0E, 1'b1, 8'd18);
    send(4'd5, 1'b1);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_data", out_data, 8'h05);
      check("t3_hold_ready", in_ready, 0);
      check("t3_hold_count", out_count, 1);
      @(negedge clk);
    end
    collect("t3", 8'h05, 1'b0, 8'd1);
    send(4'd3, 1'b0);
    idle_junk();
    send(4'd4, 1'b0);
    idle_junk();
    send(4'd1, 1'b1);
    collect("t4", 8'h08, 1'b0, 8'd3);
    send(4'd15, 1'b0);
    send(4'd15, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    check("t5_discarded", out_valid, 0);
    send(4'd2, 1'b0);
    send(4'd2, 1'b1);
    collect("t5", 8'h04, 1'b0, 8'd2);
    send(4'hD, 1'b0);
    send(4'h2, 1'b0);
    send(4'hF, 1'b1);
`ifdef CSA_SIGNED_EN
    collect("t6", 8'hFE, 1'b0, 8'd3);
`else
    collect("t6", 8'h1E, 1'b0, 8'd3);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
